input_debouncer: RTL and testbench

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

---
 rtl/input_debouncer.sv | 78 +++++++
 tb/tb_input_debouncer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Per-channel switch debouncer: 2-flop synchronizer, stability counter, optional edge pulses.
// Latency: a steady level reaches in_stable DEBOUNCE_CYCLES+2 edges after it is first sampled.
// No backpressure: outputs update every cycle. Optional macro DEBOUNCER_EDGE_PULSE_EN enables in_rise/in_fall.
module input_debouncer #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic             clk_10mhz,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_raw,
  output logic [WIDTH-1:0] in_stable,
  output logic [WIDTH-1:0] in_rise,
  output logic [WIDTH-1:0] in_fall
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable_next;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];

  // Per-channel qualification: count consecutive mismatches, commit on the last one.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      stable_next[i] = in_stable[i];
      cnt_next[i]    = '0;
      if (sync2[i] != in_stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_next[i] = sync2[i];
          cnt_next[i]    = '0;
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  // Synchronizer, counters and debounced level; reset clears everything.
  always_ff @(posedge clk_10mhz) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      in_stable <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1     <= in_raw;
      sync2     <= sync1;
      in_stable <= stable_next;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
    end
  end

`ifdef DEBOUNCER_EDGE_PULSE_EN
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  // Edge pulses registered alongside in_stable so they line up with its change.
  always_ff @(posedge clk_10mhz) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= stable_next & ~in_stable;
      fall_q <= ~stable_next & in_stable;
    end
  end

  assign in_rise = rise_q;
  assign in_fall = fall_q;
`else
  assign in_rise = '0;
  assign in_fall = '0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with DEBOUNCE_CYCLES=4, WIDTH=5.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Edge-pulse expectations follow the DEBOUNCER_EDGE_PULSE_EN macro.
module tb_input_debouncer;

  localparam int W = 5;
`ifdef DEBOUNCER_EDGE_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_raw;
  logic [W-1:0] in_stable;
  logic [W-1:0] in_rise;
  logic [W-1:0] in_fall;

  int vectors = 0;
  int errors  = 0;

  input_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) dut (
    .clk_10mhz (clk),
    .rst       (rst),
    .in_raw    (in_raw),
    .in_stable (in_stable),
    .in_rise   (in_rise),
    .in_fall   (in_fall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pe(input logic [W-1:0] v);
    return PULSE_EN ? v : '0;
  endfunction

  task automatic check_all(input string tag, input logic [W-1:0] s,
                           input logic [W-1:0] r, input logic [W-1:0] f);
    check({tag, ".stable"}, in_stable, s);
    check({tag, ".rise"},   in_rise,   pe(r));
    check({tag, ".fall"},   in_fall,   pe(f));
  endtask

  initial begin
    rst    = 1'b1;
    in_raw = '0;
    step();
    step();
    check_all("reset", 5'b00000, 5'b00000, 5'b00000);

    // Single channel rising: set on 6th edge counting the first sampling edge.
    rst    = 1'b0;
    in_raw = 5'b00001;
    for (int n = 1; n <= 7; n++) begin
      step();
      check_all($sformatf("rise0_e%0d", n),
                (n >= 6) ? 5'b00001 : 5'b00000,
                (n == 6) ? 5'b00001 : 5'b00000, 5'b00000);
    end

    // Three-cycle glitch on channel 1 must be rejected.
    in_raw = 5'b00011;
    step(); step(); step();
    in_raw = 5'b00001;
    for (int n = 1; n <= 10; n++) begin
      step();
      check_all($sformatf("glitch1_c%0d", n), 5'b00001, 5'b00000, 5'b00000);
    end

    // All channels high, then all fall together.
    in_raw = 5'b11111;
    for (int n = 1; n <= 7; n++) begin
      step();
      check_all($sformatf("allhi_e%0d", n),
                (n >= 6) ? 5'b11111 : 5'b00001,
                (n == 6) ? 5'b11110 : 5'b00000, 5'b00000);
    end
    in_raw = 5'b00000;
    for (int n = 1; n <= 7; n++) begin
      step();
      check_all($sformatf("alllo_e%0d", n),
                (n >= 6) ? 5'b00000 : 5'b11111, 5'b00000,
                (n == 6) ? 5'b11111 : 5'b00000);
    end

    // Reset mid-count on channel 2 (counter at 2), then requalify from zero.
    in_raw = 5'b00100;
    for (int n = 1; n <= 4; n++) begin
      step();
      check_all($sformatf("precnt_e%0d", n), 5'b00000, 5'b00000, 5'b00000);
    end
    rst = 1'b1;
    step();
    check_all("midrst", 5'b00000, 5'b00000, 5'b00000);
    rst = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      step();
      check_all($sformatf("postrst_e%0d", n),
                (n >= 6) ? 5'b00100 : 5'b00000,
                (n == 6) ? 5'b00100 : 5'b00000, 5'b00000);
    end

    // Channel 3 toggling every cycle never qualifies.
    for (int n = 1; n <= 50; n++) begin
      in_raw[3] = ~in_raw[3];
      step();
      check_all($sformatf("toggle3_c%0d", n), 5'b00100, 5'b00000, 5'b00000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
